// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, controller state encoding and the default multiply/divide latency.
package pipeline_pkg;

    localparam int MDU_LAT_DEF = 32;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_IDEX  = 2'b00;
    localparam fwd_sel_t FWD_EXMEM = 2'b10;
    localparam fwd_sel_t FWD_MEMWB = 2'b01;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MDU_WAIT = 1'b1;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one ALU source; the newer EX/MEM result
// takes precedence over MEM/WB when both match.
module fwd_unit
    import pipeline_pkg::*;
(
    input  logic     [4:0] src_addr_i,
    input  logic           exmem_reg_write_i,
    input  logic     [4:0] exmem_rd_i,
    input  logic           memwb_reg_write_i,
    input  logic     [4:0] memwb_rd_i,
    output fwd_sel_t       sel_o
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == src_addr_i);
    assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == src_addr_i);

    always_comb begin
        sel_o = FWD_IDEX;
        if (exmem_hit) begin
            sel_o = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, taken-branch flush
// and a multi-cycle MDU wait with a saturating stall-cycle counter.
//
// state    | meaning
// ST_RUN   | normal issue; branch, MDU entry and load-use are evaluated
// ST_MDU_WAIT | pipeline frozen while the multiply/divide unit finishes
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rs_addr,
    input  logic [4:0]  idex_rt_addr,
    input  logic        exmem_reg_write,
    input  logic        memwb_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic        mdu_start,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mdu_done,
    output logic [31:0] stall_count
);

    logic [0:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] stall_count_q, stall_count_d;
    fwd_sel_t    sel_a, sel_b;
    logic        load_use;

    fwd_unit u_fwd_a (
        .src_addr_i        (idex_rs_addr),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .sel_o             (sel_a)
    );

    fwd_unit u_fwd_b (
        .src_addr_i        (idex_rt_addr),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .sel_o             (sel_b)
    );

    assign fwd_a = rst_n ? sel_a : FWD_IDEX;
    assign fwd_b = rst_n ? sel_b : FWD_IDEX;

    assign load_use = idex_mem_read && (idex_rt_addr != 5'd0) &&
                      ((idex_rt_addr == id_rs_addr) || (idex_rt_addr == id_rt_addr));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mdu_done     = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (rst_n) begin
            case (state_q)
                ST_RUN: begin
                    if (branch_taken) begin
                        ifid_flush   = 1'b1;
                        idex_bubble  = 1'b1;
                        exmem_bubble = 1'b1;
                    end else if (mdu_start) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_write = 1'b0;
                        state_d    = ST_MDU_WAIT;
                        cnt_d      = 6'(MDU_LAT - 2);
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                default: begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    // Entry cycle is already one stall, so the wait ends when the
                    // decremented count would reach zero.
                    if (cnt_q <= 6'd1) begin
                        mdu_done = 1'b1;
                        state_d  = ST_RUN;
                        cnt_d    = 6'd0;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            cnt_q         <= 6'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues expected outputs per
// cycle; monitors compare them at the falling edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs_addr, id_rt_addr, idex_rs_addr, idex_rt_addr, exmem_rd, memwb_rd;
    logic        idex_mem_read, exmem_reg_write, memwb_reg_write, mdu_start, branch_taken;
    logic        pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, mdu_done;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, mdu_done}
    localparam logic [6:0] C_DEF  = 7'b1110000;
    localparam logic [6:0] C_LU   = 7'b0010100;
    localparam logic [6:0] C_BR   = 7'b1111110;
    localparam logic [6:0] C_ENT  = 7'b0000000;
    localparam logic [6:0] C_WT   = 7'b0000010;
    localparam logic [6:0] C_DONE = 7'b0000011;

    typedef struct {
        string       nm;
        logic [6:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        bit          cc;
        logic [31:0] cnt;
    } exp_t;

    exp_t expq[$];
    int   doneq[$];

    hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .idex_mem_read   (idex_mem_read),
        .idex_rs_addr    (idex_rs_addr),
        .idex_rt_addr    (idex_rt_addr),
        .exmem_reg_write (exmem_reg_write),
        .memwb_reg_write (memwb_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_rd        (memwb_rd),
        .mdu_start       (mdu_start),
        .branch_taken    (branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .mdu_done        (mdu_done),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; idex_rs_addr = 5'd0; idex_rt_addr = 5'd0;
        exmem_rd = 5'd0; memwb_rd = 5'd0; idex_mem_read = 1'b0; exmem_reg_write = 1'b0;
        memwb_reg_write = 1'b0; mdu_start = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [6:0] ctl, input logic [1:0] fa,
                              input logic [1:0] fb, input bit cc, input logic [31:0] cnt);
        exp_t e;
        e.nm = nm; e.ctl = ctl; e.fa = fa; e.fb = fb; e.cc = cc; e.cnt = cnt;
        expq.push_back(e);
    endtask

    task automatic load_use_in(input logic [4:0] rt, input logic [4:0] rs_id, input logic [4:0] rt_id);
        idex_mem_read = 1'b1; idex_rt_addr = rt; id_rs_addr = rs_id; id_rt_addr = rt_id;
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e = expq.pop_front();
            act = {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, mdu_done};
            checks++;
            if (act !== e.ctl || fwd_a !== e.fa || fwd_b !== e.fb || (e.cc && stall_count !== e.cnt)) begin
                failures++;
                $display("FAIL %s: got ctl=%b fa=%b fb=%b cnt=%h, expected ctl=%b fa=%b fb=%b cnt=%h",
                         e.nm, act, fwd_a, fwd_b, stall_count, e.ctl, e.fa, e.fb, e.cnt);
            end
        end
    end

    always @(negedge clk) begin
        if (mdu_done === 1'b1) begin
            checks++;
            if (doneq.size() == 0) begin
                failures++;
                $display("FAIL mdu_done_unexpected: pulse at cycle %0d, expected none", cyc);
            end else begin
                int want;
                want = doneq.pop_front();
                if (want != cyc) begin
                    failures++;
                    $display("FAIL mdu_done_cycle: pulse at cycle %0d, expected cycle %0d", cyc, want);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clear_in();

        // Outputs gated while reset is held, even with hazards present.
        tick();
        load_use_in(5'd5, 5'd5, 5'd0);
        branch_taken = 1'b1; exmem_reg_write = 1'b1; exmem_rd = 5'd3; idex_rs_addr = 5'd3;
        expect_out("reset_gate", C_DEF, 2'b00, 2'b00, 1, 32'd0);
        tick(); rst_n = 1'b1; clear_in();
        expect_out("idle", C_DEF, 2'b00, 2'b00, 1, 32'd0);

        tick(); clear_in(); load_use_in(5'd5, 5'd5, 5'd0);
        expect_out("load_use_rs", C_LU, 2'b00, 2'b00, 1, 32'd0);
        tick(); clear_in();
        expect_out("after_load_use", C_DEF, 2'b00, 2'b00, 1, 32'd1);
        tick(); clear_in(); load_use_in(5'd5, 5'd0, 5'd5);
        expect_out("load_use_rt", C_LU, 2'b00, 2'b00, 1, 32'd1);
        tick(); clear_in(); load_use_in(5'd0, 5'd0, 5'd0);
        expect_out("load_rt_zero", C_DEF, 2'b00, 2'b00, 1, 32'd2);
        tick(); clear_in(); idex_rt_addr = 5'd5; id_rs_addr = 5'd5;
        expect_out("no_load", C_DEF, 2'b00, 2'b00, 1, 32'd2);

        tick(); clear_in();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; memwb_reg_write = 1'b1; memwb_rd = 5'd3; idex_rs_addr = 5'd3;
        expect_out("fwd_a_exmem", C_DEF, 2'b10, 2'b00, 1, 32'd2);
        tick(); exmem_rd = 5'd0;
        expect_out("fwd_a_memwb", C_DEF, 2'b01, 2'b00, 1, 32'd2);
        tick(); clear_in(); exmem_reg_write = 1'b1; exmem_rd = 5'd3; idex_rt_addr = 5'd3;
        expect_out("fwd_b_exmem", C_DEF, 2'b00, 2'b10, 1, 32'd2);
        tick(); clear_in(); memwb_reg_write = 1'b1; memwb_rd = 5'd7; idex_rt_addr = 5'd7; idex_rs_addr = 5'd7;
        expect_out("fwd_ab_memwb", C_DEF, 2'b01, 2'b01, 1, 32'd2);
        tick(); clear_in(); exmem_rd = 5'd3; memwb_rd = 5'd3; idex_rs_addr = 5'd3;
        expect_out("fwd_no_write", C_DEF, 2'b00, 2'b00, 1, 32'd2);

        tick(); clear_in(); load_use_in(5'd5, 5'd5, 5'd0); branch_taken = 1'b1; mdu_start = 1'b1;
        expect_out("branch_prio", C_BR, 2'b00, 2'b00, 1, 32'd2);
        tick(); clear_in();
        expect_out("after_branch", C_DEF, 2'b00, 2'b00, 1, 32'd2);

        // Full MDU op; stimulus ignored mid-wait, forwarding still live.
        tick(); clear_in(); load_use_in(5'd5, 5'd5, 5'd0); mdu_start = 1'b1;
        expect_out("mdu_entry", C_ENT, 2'b00, 2'b00, 1, 32'd2);
        doneq.push_back(cyc + 30);
        for (int k = 1; k <= 30; k++) begin
            tick(); clear_in();
            if (k == 5) begin branch_taken = 1'b1; mdu_start = 1'b1; end
            if (k == 6) begin exmem_reg_write = 1'b1; exmem_rd = 5'd3; idex_rs_addr = 5'd3; end
            expect_out($sformatf("mdu_wait_%0d", k), (k == 30) ? C_DONE : C_WT,
                       (k == 6) ? 2'b10 : 2'b00, 2'b00, 1, 32'd2 + 32'(k));
        end
        tick(); clear_in();
        expect_out("mdu_back_run", C_DEF, 2'b00, 2'b00, 1, 32'd33);
        tick(); clear_in(); load_use_in(5'd5, 5'd5, 5'd0);
        expect_out("load_use_post_mdu", C_LU, 2'b00, 2'b00, 1, 32'd33);

        // Reset on the 10th wait cycle aborts the op without a done pulse.
        tick(); clear_in(); mdu_start = 1'b1;
        expect_out("abort_entry", C_ENT, 2'b00, 2'b00, 1, 32'd34);
        for (int k = 1; k <= 9; k++) begin
            tick(); clear_in();
            expect_out($sformatf("abort_wait_%0d", k), C_WT, 2'b00, 2'b00, 1, 32'd34 + 32'(k));
        end
        tick(); clear_in(); rst_n = 1'b0;
        expect_out("abort_reset", C_DEF, 2'b00, 2'b00, 1, 32'd44);
        tick(); rst_n = 1'b1;
        expect_out("abort_after", C_DEF, 2'b00, 2'b00, 1, 32'd0);
        tick();
        expect_out("abort_idle", C_DEF, 2'b00, 2'b00, 1, 32'd0);

        // Saturation: preload the counter near the top during a long stall.
        tick(); clear_in(); mdu_start = 1'b1;
        expect_out("sat_entry", C_ENT, 2'b00, 2'b00, 1, 32'd0);
        doneq.push_back(cyc + 30);
        tick(); clear_in();
        expect_out("sat_wait_1", C_WT, 2'b00, 2'b00, 1, 32'd1);
        #5;
        force dut.stall_count_q = 32'hFFFF_FFFE;
        tick();
        release dut.stall_count_q;
        expect_out("sat_wait_2", C_WT, 2'b00, 2'b00, 0, 32'd0);
        for (int k = 3; k <= 30; k++) begin
            tick();
            expect_out($sformatf("sat_wait_%0d", k), (k == 30) ? C_DONE : C_WT,
                       2'b00, 2'b00, 1, 32'hFFFF_FFFF);
        end
        tick();
        expect_out("sat_hold", C_DEF, 2'b00, 2'b00, 1, 32'hFFFF_FFFF);

        tick(); tick();
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        checks++;
        if (expq.size() != 0 || doneq.size() != 0) begin
            failures++;
            $display("FAIL drain: pending expectations %0d, pending done pulses %0d, expected 0 and 0",
                     expq.size(), doneq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
